// File: rtl/main_memory_model.sv
// Block-granular main memory behind the cache: one outstanding 128-bit read or write,
// completing LATENCY cycles after acceptance. Optional statistics under MEM_STATS_EN.
module main_memory_model #(
  parameter int unsigned BLK_ADDR_BITS = 12,
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  mem_req_addr,
  input  logic [127:0] mem_req_dataout,
  input  logic         mem_req_rw,
  input  logic         mem_req_valid,
  output logic [127:0] mem_req_datain,
  output logic         mem_req_ready
`ifdef MEM_STATS_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`endif
);

  localparam int unsigned DEPTH  = 1 << BLK_ADDR_BITS;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [BLK_ADDR_BITS-1:0] idx_q, idx_d;
  logic                     rw_q, rw_d;
  logic [127:0]             wdata_q, wdata_d;
  logic [127:0]             datain_q, datain_d;
  logic                     ready_q, ready_d;
  logic                     rd_done_s;
  logic                     wr_done_s;

  // Backing store starts zeroed and is deliberately untouched by reset.
  logic [127:0] store_q [DEPTH] = '{default: 128'd0};

  // Offset and alias bits of the address never reach the store.
  logic unused_addr_s;
  assign unused_addr_s = ^{mem_req_addr[31:BLK_ADDR_BITS+4], mem_req_addr[3:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    datain_d  = datain_q;
    ready_d   = ready_q;
    rd_done_s = 1'b0;
    wr_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_valid) begin
          idx_d   = mem_req_addr[BLK_ADDR_BITS+3:4];
          rw_d    = mem_req_rw;
          wdata_d = mem_req_dataout;
          cnt_d   = LAT_M1;
          ready_d = 1'b0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Completion edge: the single store access happens only here.
        if (cnt_q == 8'd0) begin
          ready_d = 1'b1;
          state_d = IDLE;
          if (rw_q) begin
            wr_done_s = 1'b1;
          end else begin
            rd_done_s = 1'b1;
            datain_d  = store_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= 128'd0;
      datain_q <= 128'd0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      datain_q <= datain_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_done_s) begin
      store_q[idx_q] <= wdata_q;
    end
  end

  assign mem_req_datain = datain_q;
  assign mem_req_ready  = ready_q;

`ifdef MEM_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Saturating completion counters.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_done_s && (rd_cnt_q != {CNT_W{1'b1}})) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (wr_done_s && (wr_cnt_q != {CNT_W{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w_s;
  assign unused_cnt_w_s = '0;
`endif

endmodule

// File: tb/tb_main_memory_model.sv
// Scoreboard bench for main_memory_model: a LATENCY=4 instance and a LATENCY=1, CNT_W=2 instance.
module tb_main_memory_model;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  rd;
    logic [15:0]  wr;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [31:0]  req_addr  [2];
  logic [127:0] req_data  [2];
  logic         req_rw    [2];
  logic         req_valid [2];
  logic [127:0] dat       [2];
  logic         rdy       [2];
  logic [15:0]  rdc0, wrc0;
  logic [1:0]   rdc1, wrc1;

  int           n_cmp = 0;
  int           n_bad = 0;
  exp_t         exp_q [2][$];
  logic [127:0] model [int];
  logic [127:0] last_dat [2];
  logic [15:0]  exp_rd [2];
  logic [15:0]  exp_wr [2];
  int           lat_of [2] = '{4, 1};
  logic [15:0]  cmax_of [2] = '{16'hFFFF, 16'h0003};

  main_memory_model #(.BLK_ADDR_BITS(12), .LATENCY(4), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .mem_req_addr(req_addr[0]), .mem_req_dataout(req_data[0]),
    .mem_req_rw(req_rw[0]), .mem_req_valid(req_valid[0]),
    .mem_req_datain(dat[0]), .mem_req_ready(rdy[0])
`ifdef MEM_STATS_EN
    , .rd_count(rdc0), .wr_count(wrc0)
`endif
  );

  main_memory_model #(.BLK_ADDR_BITS(12), .LATENCY(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_req_addr(req_addr[1]), .mem_req_dataout(req_data[1]),
    .mem_req_rw(req_rw[1]), .mem_req_valid(req_valid[1]),
    .mem_req_datain(dat[1]), .mem_req_ready(rdy[1])
`ifdef MEM_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1)
`endif
  );

`ifndef MEM_STATS_EN
  assign rdc0 = 16'd0;
  assign wrc0 = 16'd0;
  assign rdc1 = 2'd0;
  assign wrc1 = 2'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on every ready rise, pop the expected completion and compare.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    int   low_cnt = 0;
    logic prev_rdy = 1'b1;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n) begin
        low_cnt  = 0;
        prev_rdy = 1'b1;
      end else begin
        if (!rdy[g]) begin
          low_cnt++;
        end else if (!prev_rdy) begin
          if (exp_q[g].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_completion dut%0d: got completion required none", g);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("datain dut%0d", g), dat[g], e.data);
            chk($sformatf("busy_cycles dut%0d", g), 128'(low_cnt), 128'(lat_of[g]));
`ifdef MEM_STATS_EN
            chk($sformatf("rd_count dut%0d", g), (g == 0) ? 128'(rdc0) : 128'(rdc1), 128'(e.rd));
            chk($sformatf("wr_count dut%0d", g), (g == 0) ? 128'(wrc0) : 128'(wrc1), 128'(e.wr));
`endif
          end
          low_cnt = 0;
        end
        prev_rdy = rdy[g];
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where ready is back.
  task automatic issue(input int d, input logic rw, input logic [31:0] a,
                       input logic [127:0] data, input bit inject);
    exp_t e;
    int   key;
    bit   done;
    key = d * 65536 + int'(a[15:4]);
    if (rw) begin
      model[key] = data;
      e.data = last_dat[d];
      if (exp_wr[d] != cmax_of[d]) exp_wr[d]++;
    end else begin
      e.data = model.exists(key) ? model[key] : 128'd0;
      last_dat[d] = e.data;
      if (exp_rd[d] != cmax_of[d]) exp_rd[d]++;
    end
    e.rd = exp_rd[d];
    e.wr = exp_wr[d];
    exp_q[d].push_back(e);
    req_addr[d]  = a;
    req_rw[d]    = rw;
    req_data[d]  = data;
    req_valid[d] = 1'b1;
    @(negedge clk);
    // Garbage on the inputs while busy must not matter.
    req_valid[d] = inject;
    req_addr[d]  = ~a;
    req_rw[d]    = ~rw;
    req_data[d]  = ~data;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rdy[d]) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        if (i == 1) req_valid[d] = 1'b0;
      end
    end
    req_valid[d] = 1'b0;
    chk($sformatf("ready_returns dut%0d", d), 128'(done), 128'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = 32'd0; req_data[d] = 128'd0; req_rw[d] = 1'b0; req_valid[d] = 1'b0;
      last_dat[d] = 128'd0; exp_rd[d] = 16'd0; exp_wr[d] = 16'd0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("reset_ready", 128'(rdy[0]), 128'd1);
      chk("reset_datain", dat[0], 128'd0);
`ifdef MEM_STATS_EN
      chk("reset_rd_count", 128'(rdc0), 128'd0);
      chk("reset_wr_count", 128'(wrc0), 128'd0);
`endif
    end

    issue(0, 1'b1, 32'h0000_0120, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0);
    issue(0, 1'b0, 32'h0000_012C, 128'd0, 1'b0);
    issue(0, 1'b0, 32'h0000_0450, 128'd0, 1'b1);
    issue(0, 1'b1, 32'h0000_2040, {4{32'hAAAA_AAAA}}, 1'b0);
    issue(0, 1'b0, 32'h0000_2040, 128'd0, 1'b0);
    issue(0, 1'b0, 32'h0001_2040, 128'd0, 1'b0);

    // Reset during the second BUSY cycle of a write must abort it.
    req_addr[0] = 32'h0000_0080; req_rw[0] = 1'b1;
    req_data[0] = {4{32'h5555_5555}}; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 128'(rdy[0]), 128'd1);
    chk("abort_datain", dat[0], 128'd0);
    for (int d = 0; d < 2; d++) begin
      last_dat[d] = 128'd0; exp_rd[d] = 16'd0; exp_wr[d] = 16'd0;
    end
    issue(0, 1'b0, 32'h0000_0080, 128'd0, 1'b0);

    issue(1, 1'b1, 32'h0000_0030, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
    for (int r = 0; r < 5; r++) begin
      issue(1, 1'b0, 32'h0000_0030, 128'd0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queue0_drained", 128'(exp_q[0].size()), 128'd0);
    chk("queue1_drained", 128'(exp_q[1].size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
